// File: rtl/imm_gen_pkg.sv
// Shared types for the immediate generator pipe.
// Defining IMM_GEN_ERR_EN adds a per-entry error flag to the stored entry.
package imm_gen_pkg;

    localparam int IMM_W_MAX = 64;
    localparam int TAG_W_MAX = 32;

    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_U     = 3'b010,
        IMM_SHAMT = 3'b011,
        IMM_ZIMM  = 3'b100,
        IMM_B     = 3'b101,
        IMM_J     = 3'b110,
        IMM_ILL   = 3'b111
    } imm_src_e;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } fifo_state_e;

    // Sized for the widest build; narrower XLEN/TAG_W use the low bits.
    typedef struct packed {
        logic [IMM_W_MAX-1:0] imm;
        logic [TAG_W_MAX-1:0] tag;
`ifdef IMM_GEN_ERR_EN
        logic                 err;
`endif
    } imm_entry_t;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational immediate extraction for all RISC-V style formats.
// Illegal format codes produce zero and raise the illegal flag.
module imm_format_decode #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);
    import imm_gen_pkg::*;

    logic signed [31:0] raw_s;
    logic               unused_opcode;

    // Every 32-bit format value is already sign-correct, so widening is a plain sign extension.
    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    always_comb begin
        raw_s   = '0;
        illegal = 1'b0;
        case (imm_src_e'(imm_src))
            IMM_I:     raw_s = {{20{instr[31]}}, instr[31:20]};
            IMM_S:     raw_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_U:     raw_s = {instr[31:12], 12'h000};
            IMM_SHAMT: raw_s = (XLEN == 64) ? {26'd0, instr[25:20]} : {27'd0, instr[24:20]};
            IMM_ZIMM:  raw_s = {27'd0, instr[19:15]};
            IMM_B:     raw_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:     raw_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:   illegal = 1'b1;
        endcase
        imm = sext32(raw_s);
    end

    assign unused_opcode = ^instr[6:0];

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a 2-entry result FIFO and valid/ready on both sides.
// Define IMM_GEN_ERR_EN to add the err port and per-entry error storage.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_ext,
    output logic [TAG_W-1:0] out_tag
`ifdef IMM_GEN_ERR_EN
    ,
    output logic             err
`endif
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    fifo_state_e     state_q, state_d;
    logic            in_ready_q, in_ready_d;
    imm_entry_t      entry0_q, entry0_d;
    imm_entry_t      entry1_q, entry1_d;
    imm_entry_t      new_entry;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    logic            accept;
    logic            pop;
    logic            unused_bits;

    imm_format_decode #(.XLEN(XLEN)) u_decode (
        .instr   (instr),
        .imm_src (imm_src),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    always_comb begin
        new_entry     = '0;
        new_entry.imm = IMM_W_MAX'($signed(dec_imm));
        new_entry.tag = TAG_W_MAX'(in_tag);
`ifdef IMM_GEN_ERR_EN
        new_entry.err = dec_illegal;
`endif
    end

    assign accept    = in_valid && in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign pop       = out_valid && out_ready;
    assign in_ready  = in_ready_q;

    // entry0 is always the head; entry1 only holds the second result while FULL.
    always_comb begin
        state_d  = state_q;
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d  = ONE;
                    entry0_d = new_entry;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    entry0_d = new_entry;
                end else if (accept) begin
                    state_d  = FULL;
                    entry1_d = new_entry;
                end else if (pop) begin
                    state_d  = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d  = ONE;
                    entry0_d = entry1_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        entry0_q <= entry0_d;
        entry1_q <= entry1_d;
    end

    // Data registers are not reset; the head is masked whenever nothing is stored.
    assign imm_ext = out_valid ? entry0_q.imm[XLEN-1:0] : '0;
    assign out_tag = out_valid ? entry0_q.tag[TAG_W-1:0] : '0;

`ifdef IMM_GEN_ERR_EN
    assign err         = out_valid && entry0_q.err;
    assign unused_bits = ^entry0_q;
`else
    assign unused_bits = ^{entry0_q, dec_illegal};
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN 32 and 64 instances share one stimulus stream
// and are checked against a queue-based reference model every cycle.
module tb_imm_gen_pipe;

    localparam int TAG_W = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  imm_src;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        rdy32, vld32, rdy64, vld64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [4:0]  tag32, tag64;
`ifdef IMM_GEN_ERR_EN
    logic        err32, err64;
`endif

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) u_dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
        .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
        .out_valid(vld32), .out_ready(out_ready), .imm_ext(imm32), .out_tag(tag32)
`ifdef IMM_GEN_ERR_EN
        , .err(err32)
`endif
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) u_dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64),
        .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
        .out_valid(vld64), .out_ready(out_ready), .imm_ext(imm64), .out_tag(tag64)
`ifdef IMM_GEN_ERR_EN
        , .err(err64)
`endif
    );

    typedef struct {
        logic [63:0] e32;
        logic [63:0] e64;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [4:0]  tag;
        logic [31:0] exp32;
        logic [63:0] exp64;
        logic        err;
    } vec_t;

    exp_t       q[$];
    logic [4:0] popped[$];
    vec_t       tbl[10];
    bit         exp_rdy;
    bit         rst_state;
    bit         last_acc;
    int         n_vec;
    int         n_fail;
    int         n_acc;

    // Field value as an integer, sign-corrected by arithmetic, then cut to XLEN.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src, input int xlen);
        longint f;
        int     n;
        f = 0;
        n = 0;
        case (src)
            3'd0: begin f = longint'(ins[31:20]); n = 12; end
            3'd1: begin f = longint'({ins[31:25], ins[11:7]}); n = 12; end
            3'd2: begin f = longint'(ins[31:12]) * 4096; n = 32; end
            3'd3: f = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
            3'd4: f = longint'(ins[19:15]);
            3'd5: begin f = longint'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); n = 13; end
            3'd6: begin f = longint'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); n = 21; end
            default: f = 0;
        endcase
        if (n > 0 && f >= (longint'(1) <<< (n - 1)))
            f = f - (longint'(1) <<< n);
        if (xlen == 32)
            return {32'd0, f[31:0]};
        return f;
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] ins, input logic [2:0] src, input logic [4:0] tg);
        exp_t e;
        e.e32 = ref_imm(ins, src, 32);
        e.e64 = ref_imm(ins, src, 64);
        e.tag = tg;
        e.err = (src == 3'b111);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: check outputs at negedge, then advance the model at posedge.
    task automatic step();
        bit acc;
        bit pp;
        @(negedge clk);
        chk("in_ready32", 64'(rdy32), 64'(exp_rdy));
        chk("in_ready64", 64'(rdy64), 64'(exp_rdy));
        chk("out_valid32", 64'(vld32), 64'(q.size() != 0));
        chk("out_valid64", 64'(vld64), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("imm32", 64'(imm32), q[0].e32);
            chk("imm64", imm64, q[0].e64);
            chk("tag32", 64'(tag32), 64'(q[0].tag));
            chk("tag64", 64'(tag64), 64'(q[0].tag));
`ifdef IMM_GEN_ERR_EN
            chk("err32", 64'(err32), 64'(q[0].err));
            chk("err64", 64'(err64), 64'(q[0].err));
`endif
        end else if (rst_state) begin
            chk("rst_imm32", 64'(imm32), 64'd0);
            chk("rst_imm64", imm64, 64'd0);
            chk("rst_tag32", 64'(tag32), 64'd0);
`ifdef IMM_GEN_ERR_EN
            chk("rst_err32", 64'(err32), 64'd0);
`endif
        end
        acc = in_valid && exp_rdy;
        pp  = (q.size() != 0) && out_ready;
        @(posedge clk);
        last_acc = 1'b0;
        if (reset) begin
            q.delete();
            exp_rdy   = 1'b0;
            rst_state = 1'b1;
        end else begin
            rst_state = 1'b0;
            if (pp) begin
                popped.push_back(q[0].tag);
                void'(q.pop_front());
            end
            if (acc) begin
                q.push_back(mk_exp(instr, imm_src, in_tag));
                n_acc++;
                last_acc = 1'b1;
            end
            exp_rdy = (q.size() < 2);
        end
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_fail = 0; n_acc = 0;
        reset = 1'b1; in_valid = 1'b0; instr = '0; imm_src = '0; in_tag = '0; out_ready = 1'b0;

        tbl[0] = '{32'hFFF00093, 3'd0, 5'd1,  32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        tbl[1] = '{32'hFE000EE3, 3'd5, 5'd2,  32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        tbl[2] = '{32'h800000B7, 3'd2, 5'd3,  32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
        tbl[3] = '{32'hFFFFFFFF, 3'd7, 5'd4,  32'h00000000, 64'h0000000000000000, 1'b1};
        tbl[4] = '{32'h000F8000, 3'd4, 5'd5,  32'h0000001F, 64'h000000000000001F, 1'b0};
        tbl[5] = '{32'hFE112E23, 3'd1, 5'd6,  32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        tbl[6] = '{32'h8000006F, 3'd6, 5'd7,  32'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0};
        tbl[7] = '{32'h03F00013, 3'd3, 5'd8,  32'h0000001F, 64'h000000000000003F, 1'b0};
        tbl[8] = '{32'h7FF00013, 3'd0, 5'd9,  32'h000007FF, 64'h00000000000007FF, 1'b0};
        tbl[9] = '{32'h12345678, 3'd2, 5'd31, 32'h12345000, 64'h0000000012345000, 1'b0};

        @(posedge clk);
        #1;
        q.delete(); exp_rdy = 1'b0; rst_state = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("in_ready_after_reset", 64'(rdy32), 64'd1);

        // Table vectors, one at a time through an empty FIFO.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; instr = tbl[i].instr; imm_src = tbl[i].src; in_tag = tbl[i].tag;
            step();
            in_valid = 1'b0;
            chk("tbl_valid", 64'(vld32), 64'd1);
            chk("tbl_imm32", 64'(imm32), 64'(tbl[i].exp32));
            chk("tbl_imm64", imm64, tbl[i].exp64);
            chk("tbl_tag", 64'(tag64), 64'(tbl[i].tag));
`ifdef IMM_GEN_ERR_EN
            chk("tbl_err", 64'(err64), 64'(tbl[i].err));
`endif
            instr = $urandom; imm_src = 3'($urandom);
            step();
        end

        // Backpressure: tags 1,2 fill the FIFO, tag 3 waits.
        popped.delete();
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'hFFF00093; imm_src = 3'd0;
        in_tag = 5'd1; step();
        in_tag = 5'd2; step();
        chk("full_in_ready", 64'(rdy32), 64'd0);
        in_tag = 5'd3; instr = 32'h800000B7; imm_src = 3'd2;
        step(); step();
        chk("held_head_tag", 64'(tag32), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (last_acc) in_valid = 1'b0;
        end
        chk("order_count", 64'(popped.size()), 64'd3);
        if (popped.size() == 3) begin
            chk("order_0", 64'(popped[0]), 64'd1);
            chk("order_1", 64'(popped[1]), 64'd2);
            chk("order_2", 64'(popped[2]), 64'd3);
        end

        // Streaming: 16 requests back-to-back with out_ready high.
        popped.delete(); n_acc = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            instr = $urandom; imm_src = 3'($urandom_range(0, 6)); in_tag = 5'(i);
            step();
        end
        in_valid = 1'b0;
        chk("stream_accepts", 64'(n_acc), 64'd16);
        step();
        chk("stream_results", 64'(popped.size()), 64'd16);

        // Reset from FULL discards everything.
        out_ready = 1'b0; in_valid = 1'b1;
        in_tag = 5'd10; step();
        in_tag = 5'd11; step();
        chk("pre_reset_full", 64'(rdy64), 64'd0);
        reset = 1'b1; step();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("reset_out_valid", 64'(vld32), 64'd0);
        chk("reset_in_ready", 64'(rdy32), 64'd0);
        step();
        chk("post_reset_in_ready", 64'(rdy32), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("no_stale", 64'(vld64), 64'd0);
        end

        // Random traffic, including illegal codes and idle input churn.
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom); out_ready = ($urandom_range(0, 3) != 0);
            instr = $urandom; imm_src = 3'($urandom); in_tag = 5'($urandom);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step(); step(); step();
        chk("drained", 64'(vld32), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
